inference_sequencer: RTL and testbench

Sequencing controller for the CNN classifier back end. On a start request it clears both dense accumulators, streams the early-exit dense layer (3E) element by element, and compares its confidence against a threshold. It then either retires the early class index or goes on to stream the full dense layer (6F) and retires that result. It owns the element-select counters and the accumulate enables that the top level feeds into the two `layer_dense` instances.

---
 rtl/seq_pkg.sv | 22 ++
 rtl/feed_counter.sv | 28 ++
 rtl/inference_sequencer.sv | 138 +++++++++++++
 tb/tb_inference_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state type and default sizes for the inference sequencer
package seq_pkg;

  // Defaults mirrored from definitions.v
  localparam int SIZE_E_DEF = 16;
  localparam int SIZE_F_DEF = 32;
  localparam int LAT_D_DEF  = 2;
  localparam int BIT_R_DEF  = 16;
  localparam int BIT_O_DEF  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED_E,
    S_DRAIN_E,
    S_DECIDE,
    S_FEED_F,
    S_DRAIN_F,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/feed_counter.sv
// rtl/feed_counter.sv - saturating element-select counter with registered last flag
module feed_counter #(
  parameter int SIZE = 16,
  parameter int W    = $clog2(SIZE)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         last
);

  localparam logic [W-1:0] MAX = W'(SIZE - 1);
  localparam logic [W-1:0] ONE = W'(1);

  // Count enabled elements, stop at SIZE-1, and flag the final element one cycle ahead
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
      last  <= (SIZE == 1);
    end else if (enable && (count != MAX)) begin
      count <= count + ONE;
      last  <= ((count + ONE) == MAX);
    end
  end

endmodule

// File: rtl/inference_sequencer.sv
// rtl/inference_sequencer.sv - early-exit / full dense layer sequencing controller
module inference_sequencer
  import seq_pkg::*;
#(
  parameter int SIZE_E = SIZE_E_DEF,
  parameter int SIZE_F = SIZE_F_DEF,
  parameter int LAT_D  = LAT_D_DEF,
  parameter int BIT_R  = BIT_R_DEF,
  parameter int BIT_O  = BIT_O_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [BIT_R-1:0]   thresh,
  input  logic                      ready_e,
  input  logic                      ready_f,
  input  logic signed [BIT_R-1:0]   results_early,
  input  logic [BIT_O-1:0]          index_early,
  input  logic signed [BIT_R-1:0]   results_full,
  input  logic [BIT_O-1:0]          index_full,
  output logic                      clr,
  output logic                      en_e,
  output logic                      en_f,
  output logic [$clog2(SIZE_E)-1:0] sel_e,
  output logic [$clog2(SIZE_F)-1:0] sel_f,
  output logic                      busy,
  output logic                      done,
  output logic                      early_exit,
  output logic [BIT_O-1:0]          data_out
);

  localparam int W_E = $clog2(SIZE_E);
  localparam int W_F = $clog2(SIZE_F);
  localparam int DW  = $clog2(LAT_D + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT_D - 1);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

  seq_state_t state, next_state;

  logic signed [BIT_R-1:0] thresh_q;
  logic [DW-1:0]           drain_cnt;
  logic [W_E-1:0]          cnt_e;
  logic [W_F-1:0]          cnt_f;
  logic                    last_e, last_f;
  logic                    pend_early;
  logic [BIT_O-1:0]        pend_idx;
  logic                    early_gt, drain_done;
  logic                    cnt_clear, cnt_en_e, cnt_en_f;

  // The full confidence is not part of the decision; only its index is retired
  logic unused_results_full;
  assign unused_results_full = ^results_full;

  assign early_gt   = results_early > thresh_q;
  assign drain_done = (drain_cnt == DRAIN_LAST);
  assign cnt_clear  = (state == S_CLR);
  assign cnt_en_e   = (state == S_FEED_E) && ready_e;
  assign cnt_en_f   = (state == S_FEED_F) && ready_f;

  feed_counter #(.SIZE(SIZE_E), .W(W_E)) u_feed_e (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en_e),
    .count  (cnt_e),
    .last   (last_e)
  );

  feed_counter #(.SIZE(SIZE_F), .W(W_F)) u_feed_f (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en_f),
    .count  (cnt_f),
    .last   (last_f)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state selection; feed states advance only on a ready element
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = S_CLR;
      S_CLR:     next_state = S_FEED_E;
      S_FEED_E:  if (ready_e && last_e) next_state = S_DRAIN_E;
      S_DRAIN_E: if (drain_done) next_state = S_DECIDE;
      S_DECIDE:  next_state = early_gt ? S_DONE : S_FEED_F;
      S_FEED_F:  if (ready_f && last_f) next_state = S_DRAIN_F;
      S_DRAIN_F: if (drain_done) next_state = S_DONE;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Registered outputs, threshold latch, drain timer and the pending early decision
  always_ff @(posedge clock) begin
    if (reset) begin
      thresh_q   <= '0;
      drain_cnt  <= '0;
      pend_early <= 1'b0;
      pend_idx   <= '0;
      clr        <= 1'b0;
      en_e       <= 1'b0;
      en_f       <= 1'b0;
      sel_e      <= '0;
      sel_f      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      early_exit <= 1'b0;
      data_out   <= '0;
    end else begin
      if ((state == S_IDLE) && start) thresh_q <= thresh;
      if ((state == S_DRAIN_E) || (state == S_DRAIN_F)) drain_cnt <= drain_cnt + DRAIN_ONE;
      else                                               drain_cnt <= '0;
      if (state == S_DECIDE) begin
        pend_early <= early_gt;
        pend_idx   <= index_early;
      end
      clr   <= (state == S_CLR);
      en_e  <= cnt_en_e;
      en_f  <= cnt_en_f;
      sel_e <= cnt_e;
      sel_f <= cnt_f;
      busy  <= (state != S_IDLE);
      done  <= (state == S_DONE);
      if (state == S_DONE) begin
        early_exit <= pend_early;
        data_out   <= pend_early ? pend_idx : index_full;
      end
    end
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// tb/tb_inference_sequencer.sv - scoreboard bench for inference_sequencer
module tb_inference_sequencer;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic signed [15:0] thresh = '0;
  logic               ready_e = 1'b1;
  logic               ready_f = 1'b1;
  logic signed [15:0] results_early = '0;
  logic [3:0]         index_early = '0;
  logic signed [15:0] results_full = '0;
  logic [3:0]         index_full = '0;
  logic               clr, en_e, en_f, busy, done, early_exit;
  logic [3:0]         sel_e;
  logic [4:0]         sel_f;
  logic [3:0]         data_out;

  inference_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .thresh        (thresh),
    .ready_e       (ready_e),
    .ready_f       (ready_f),
    .results_early (results_early),
    .index_early   (index_early),
    .results_full  (results_full),
    .index_full    (index_full),
    .clr           (clr),
    .en_e          (en_e),
    .en_f          (en_f),
    .sel_e         (sel_e),
    .sel_f         (sel_f),
    .busy          (busy),
    .done          (done),
    .early_exit    (early_exit),
    .data_out      (data_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int done_cyc;
    int clr_cyc;
    int data;
    int ee;
    int ne;
    int nf;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: tracks per-run activity and retires scoreboard entries on done
  int ecnt = 0, fcnt = 0, clr_cnt = 0, clr_cyc = -1;
  int last_data = 0, last_ee = 0;
  always @(negedge clock) begin
    if (reset) begin
      ecnt = 0; fcnt = 0; clr_cnt = 0; clr_cyc = -1;
      last_data = 0; last_ee = 0;
    end else begin
      if (clr) begin
        clr_cnt++;
        clr_cyc = cyc;
        ecnt = 0;
        fcnt = 0;
      end
      if (en_e || en_f) chk("en_exclusive", int'(en_e && en_f), 0);
      if (en_e) begin
        chk("sel_e", int'(sel_e), ecnt);
        ecnt++;
      end
      if (en_f) begin
        chk("sel_f", int'(sel_f), fcnt);
        fcnt++;
      end
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("clr_cycle", clr_cyc, e.clr_cyc);
          chk("clr_per_run", clr_cnt, 1);
          chk("data_out", int'(data_out), e.data);
          chk("early_exit", int'(early_exit), e.ee);
          chk("en_e_pulses", ecnt, e.ne);
          chk("en_f_pulses", fcnt, e.nf);
        end
        last_data = int'(data_out);
        last_ee   = int'(early_exit);
        clr_cnt   = 0;
      end else begin
        chk("data_out_hold", int'(data_out), last_data);
        chk("early_exit_hold", int'(early_exit), last_ee);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 300 && sbq.size() != 0; i++) step();
    chk("run_completed", sbq.size(), 0);
    step();
  endtask

  // Issues a start with the given operands and pushes the expected result
  task automatic launch(input int thr, input int re, input int ie, input int ifl,
                        input bit early, input int stall);
    exp_t e;
    int t;
    thresh        = 16'(thr);
    results_early = 16'(re);
    index_early   = 4'(ie);
    results_full  = 16'(re - 1);
    index_full    = 4'(ifl);
    start = 1'b1;
    t = cyc + 1;
    e.clr_cyc  = t + 1;
    e.done_cyc = t + (early ? 21 : 55) + stall;
    e.data     = early ? ie : ifl;
    e.ee       = early ? 1 : 0;
    e.ne       = 16;
    e.nf       = early ? 0 : 32;
    sbq.push_back(e);
    step();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle %0d", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    exp_t e2;
    int d;
    bit seen;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_clr", int'(clr), 0);
    chk("reset_en", int'({en_e, en_f}), 0);
    chk("reset_sel", int'({sel_e, sel_f}), 0);
    chk("reset_data_out", int'(data_out), 0);

    // Early exit
    launch(70, 100, 5, 9, 1'b1, 0);
    wait_empty();

    // Equality falls through to the full path
    launch(70, 70, 3, 11, 1'b0, 0);
    wait_empty();

    // Three-cycle stall on ready_e mid feed
    launch(70, 100, 6, 1, 1'b1, 3);
    repeat (3) step();
    ready_e = 1'b0;
    repeat (3) step();
    ready_e = 1'b1;
    wait_empty();

    // Signed compare in both directions
    launch(-5, -3, 2, 8, 1'b1, 0);
    wait_empty();
    launch(-3, -5, 4, 13, 1'b0, 0);
    wait_empty();

    // Start held high: one clr per run, second clr two cycles after done
    launch(10, 20, 12, 1, 1'b1, 0);
    start = 1'b1;
    d = sbq[0].done_cyc;
    e2.clr_cyc  = d + 2;
    e2.done_cyc = d + 22;
    e2.data = 12; e2.ee = 1; e2.ne = 16; e2.nf = 0;
    sbq.push_back(e2);
    for (int i = 0; i < 100 && sbq.size() > 1; i++) step();
    start = 1'b0;
    wait_empty();

    // Reset in the middle of the full layer feed
    launch(70, 0, 1, 10, 1'b0, 0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (en_f && sel_f == 5'd10) seen = 1'b1;
      else step();
    end
    chk("reached_sel_f_10", int'(seen), 1);
    reset = 1'b1;
    sbq.delete();
    step();
    reset = 1'b0;
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_sel_f", int'(sel_f), 0);
    chk("midreset_data_out", int'(data_out), 0);
    chk("midreset_en_f", int'(en_f), 0);
    step();
    launch(70, 50, 2, 7, 1'b0, 0);
    wait_empty();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
